// File: rtl/proc_monitor_deadline_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : proc_monitor_deadline_checker_if                                |
// | Brief    : 16-bit Avalon-MM register port of the deadline checker          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface proc_monitor_deadline_checker_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/proc_monitor_deadline_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : proc_monitor_deadline_checker                                   |
// | Brief    : per-core tick-budget watchdog with sticky expiry and irq        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module proc_monitor_deadline_checker #(
  parameter int NUM_CORES = 4,
  parameter int TICK_W    = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 tick,
  input  wire logic [NUM_CORES-1:0] heartbeat,
  proc_monitor_deadline_checker_if.slave bus,
  output logic                      irq,
  output logic [NUM_CORES-1:0]      expired
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  localparam logic [3:0] c_addr_status  = 4'd0;
  localparam logic [3:0] c_addr_control = 4'd1;
  localparam logic [3:0] c_addr_arm     = 4'd2;
  localparam logic [3:0] c_addr_disarm  = 4'd3;

  logic        w_wr;
  logic        w_wr_status;
  logic        w_wr_arm;
  logic        w_wr_disarm;
  logic        r_irq_en;
  logic [15:0] r_readdata;
  logic [15:0] w_rd_next;
  logic [3:0]  w_exp_rd;
  logic [3:0]  w_arm_rd;
  logic [15:0] w_budget_rd    [4];
  logic [15:0] w_remaining_rd [4];

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wr_status = w_wr & (bus.address == c_addr_status);
  assign w_wr_arm    = w_wr & (bus.address == c_addr_arm);
  assign w_wr_disarm = w_wr & (bus.address == c_addr_disarm);

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      localparam logic [3:0] c_addr_budget = 4'(4 + i);

      state_t            r_state;
      logic [TICK_W-1:0] r_budget;
      logic [TICK_W-1:0] r_remaining;
      logic              r_armed;
      logic              r_expired;
      logic              w_arm;
      logic              w_disarm;
      logic              w_clear;

      assign w_arm    = w_wr_arm    & bus.writedata[i];
      assign w_disarm = w_wr_disarm & bus.writedata[i];
      assign w_clear  = w_wr_status & bus.writedata[i];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_budget <= '0;
        end else if (w_wr && (bus.address == c_addr_budget)) begin
          r_budget <= bus.writedata[TICK_W-1:0];
        end
      end

      // Priority per core: disarm/clear, then arm, then heartbeat, then tick.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state     <= S_IDLE;
          r_remaining <= '0;
          r_armed     <= 1'b0;
          r_expired   <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_arm && !w_disarm) begin
                r_state     <= S_ARMED;
                r_remaining <= r_budget;
                r_armed     <= 1'b1;
              end
            end
            S_ARMED: begin
              if (w_disarm) begin
                r_state <= S_IDLE;
                r_armed <= 1'b0;
              end else if (w_arm || heartbeat[i]) begin
                r_remaining <= r_budget;
              end else if (tick) begin
                if (r_remaining <= TICK_W'(1)) begin
                  r_state     <= S_EXPIRED;
                  r_remaining <= '0;
                  r_armed     <= 1'b0;
                  r_expired   <= 1'b1;
                end else begin
                  r_remaining <= r_remaining - TICK_W'(1);
                end
              end
            end
            S_EXPIRED: begin
              if (w_disarm || w_clear) begin
                r_state   <= S_IDLE;
                r_expired <= 1'b0;
              end
            end
            default: begin
              r_state   <= S_IDLE;
              r_armed   <= 1'b0;
              r_expired <= 1'b0;
            end
          endcase
        end
      end

      assign expired[i]        = r_expired;
      assign w_exp_rd[i]       = r_expired;
      assign w_arm_rd[i]       = r_armed;
      assign w_budget_rd[i]    = 16'(r_budget);
      assign w_remaining_rd[i] = 16'(r_remaining);
    end

    // Slots for cores that are not instantiated read back as zero.
    for (genvar j = NUM_CORES; j < 4; j++) begin : g_pad
      assign w_exp_rd[j]       = 1'b0;
      assign w_arm_rd[j]       = 1'b0;
      assign w_budget_rd[j]    = 16'd0;
      assign w_remaining_rd[j] = 16'd0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
    end else if (w_wr && (bus.address == c_addr_control)) begin
      r_irq_en <= bus.writedata[0];
    end
  end

  always_comb begin
    w_rd_next = 16'd0;
    case (bus.address)
      4'd0:                   w_rd_next = {8'd0, w_arm_rd, w_exp_rd};
      4'd1:                   w_rd_next = {15'd0, r_irq_en};
      4'd4, 4'd5, 4'd6, 4'd7: w_rd_next = w_budget_rd[bus.address[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: w_rd_next = w_remaining_rd[bus.address[1:0]];
      default:                w_rd_next = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 16'd0;
    end else begin
      r_readdata <= w_rd_next;
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq_en & (|expired);

endmodule
`default_nettype wire

// File: tb/tb_proc_monitor_deadline_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_proc_monitor_deadline_checker                                |
// | Brief    : directed + random bench against a behavioural watchdog model    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_proc_monitor_deadline_checker;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [NC-1:0] heartbeat = '0;
  logic          irq;
  logic [NC-1:0] expired;
  int            total = 0;
  int            bad = 0;

  proc_monitor_deadline_checker_if bus_if ();

  proc_monitor_deadline_checker #(.NUM_CORES(NC), .TICK_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .heartbeat (heartbeat),
    .bus       (bus_if),
    .irq       (irq),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // Model: 0 = idle, 1 = armed, 2 = expired.
  int          m_state [NC];
  logic [15:0] m_rem   [NC];
  logic [15:0] m_bud   [NC];
  bit          m_irq_en;
  logic [15:0] m_rd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdl_read(input int a);
    logic [15:0] v = 16'd0;
    if (a == 0) begin
      for (int i = 0; i < NC; i++) begin
        if (m_state[i] == 2) v[i] = 1'b1;
        if (m_state[i] == 1) v[i+4] = 1'b1;
      end
    end else if (a == 1) v = {15'd0, m_irq_en};
    else if (a >= 4 && a < 4 + NC) v = m_bud[a-4];
    else if (a >= 8 && a < 8 + NC) v = m_rem[a-8];
    return v;
  endfunction

  function automatic logic [15:0] mdl_expired();
    logic [15:0] v = 16'd0;
    for (int i = 0; i < NC; i++) v[i] = (m_state[i] == 2);
    return v;
  endfunction

  task automatic mdl_step();
    int          a  = int'(bus_if.address);
    logic [15:0] d  = bus_if.writedata;
    bit          wr = bus_if.chipselect && !bus_if.write_n;
    for (int i = 0; i < NC; i++) begin
      bit arm = wr && a == 2 && d[i];
      bit dis = wr && a == 3 && d[i];
      bit clr = wr && a == 0 && d[i];
      if (m_state[i] == 0) begin
        if (arm && !dis) begin m_state[i] = 1; m_rem[i] = m_bud[i]; end
      end else if (m_state[i] == 1) begin
        if (dis) m_state[i] = 0;
        else if (arm || heartbeat[i]) m_rem[i] = m_bud[i];
        else if (tick) begin
          if (m_rem[i] <= 1) begin m_state[i] = 2; m_rem[i] = 0; end
          else m_rem[i] = m_rem[i] - 16'd1;
        end
      end else if (dis || clr) m_state[i] = 0;
    end
    for (int i = 0; i < NC; i++) if (wr && a == 4 + i) m_bud[i] = d;
    if (wr && a == 1) m_irq_en = d[0];
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) begin m_state[i] = 0; m_rem[i] = 0; m_bud[i] = 0; end
      m_irq_en = 1'b0;
      m_rd = 16'd0;
    end else begin
      m_rd = mdl_read(int'(bus_if.address));
      mdl_step();
    end
    #1;
    chk("cyc_readdata", bus_if.readdata, m_rd);
    chk("cyc_expired", 16'(expired), mdl_expired());
    chk("cyc_irq", {15'd0, irq}, {15'd0, m_irq_en && (mdl_expired() != 0)});
  end

  task automatic step(input bit cs, input bit wn, input logic [3:0] a, input logic [15:0] d,
                      input bit tk, input logic [NC-1:0] hb);
    @(negedge clk);
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick              = tk;
    heartbeat         = hb;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string name);
    step(1'b0, 1'b1, a, 16'd0, 1'b0, '0);
    chk(name, bus_if.readdata, exp);
  endtask

  task automatic tk();
    step(1'b0, 1'b1, 4'd0, 16'd0, 1'b1, '0);
  endtask

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 4'd0;
    bus_if.writedata  = 16'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 16; a++) rd(4'(a), 16'd0, "reset_read");
    chk("reset_irq", {15'd0, irq}, 16'd0);
    chk("reset_expired", 16'(expired), 16'd0);

    // Countdown to a miss on core 0.
    wr(4'd4, 16'd3);
    wr(4'd1, 16'd1);
    wr(4'd2, 16'h1);
    rd(4'd8, 16'd3, "rem0_3");
    tk(); rd(4'd8, 16'd2, "rem0_2");
    tk(); rd(4'd8, 16'd1, "rem0_1");
    chk("not_yet_expired", 16'(expired), 16'd0);
    tk();
    chk("miss_expired", 16'(expired), 16'h1);
    chk("miss_irq", {15'd0, irq}, 16'd1);

    // Heartbeat on every tick keeps core 1 alive.
    wr(4'd5, 16'd2);
    wr(4'd2, 16'h2);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 4'd0, 16'd0, 1'b1, 4'b0010);
    rd(4'd9, 16'd2, "hb_rem1");
    chk("hb_expired", 16'(expired), 16'h1);

    // W1C returns core 0 to idle.
    wr(4'd3, 16'h2);
    wr(4'd0, 16'h1);
    chk("w1c_expired", 16'(expired), 16'd0);
    chk("w1c_irq", {15'd0, irq}, 16'd0);
    rd(4'd0, 16'd0, "w1c_status");
    tk(); tk(); tk();
    rd(4'd8, 16'd0, "idle_rem0");
    rd(4'd9, 16'd2, "disarm_hold_rem1");

    // Disarm coincident with a tick holds remaining.
    wr(4'd6, 16'd5);
    wr(4'd2, 16'h4);
    rd(4'd10, 16'd5, "rem2_5");
    step(1'b1, 1'b0, 4'd3, 16'h4, 1'b1, '0);
    rd(4'd10, 16'd5, "disarm_tick_rem2");
    rd(4'd0, 16'd0, "disarm_status");

    // Simultaneous misses with irq masked, then unmasked.
    wr(4'd1, 16'd0);
    wr(4'd4, 16'd1);
    wr(4'd5, 16'd0);
    wr(4'd2, 16'h3);
    rd(4'd0, 16'h0030, "armed_status");
    tk();
    chk("dual_expired", 16'(expired), 16'h3);
    chk("dual_irq_masked", {15'd0, irq}, 16'd0);
    wr(4'd1, 16'd1);
    chk("dual_irq_enabled", {15'd0, irq}, 16'd1);
    rd(4'd0, 16'h0003, "dual_status");

    // Asynchronous reset in the middle of a countdown.
    wr(4'd0, 16'h3);
    wr(4'd2, 16'h4);
    tk(); tk();
    rd(4'd10, 16'd3, "rem2_before_reset");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", bus_if.readdata, 16'd0);
    chk("async_rst_expired", 16'(expired), 16'd0);
    chk("async_rst_irq", {15'd0, irq}, 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++) rd(4'(a), 16'd0, "post_reset_read");

    // Random traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 4000; n++) begin
      logic [3:0]    a  = 4'($urandom_range(0, 15));
      logic [15:0]   d  = 16'($urandom);
      logic [NC-1:0] hb = '0;
      if (a >= 4'd4 && a <= 4'd7) d = 16'($urandom_range(0, 6));
      for (int i = 0; i < NC; i++) hb[i] = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), a, d,
           $urandom_range(0, 2) == 0, hb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
